// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter sharing one SDRAM slave port.
// Round-robin on ties, with bounded hold time per master under contention.
module wshb_arbiter #(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,

  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_ms,
  input  logic [3:0]  m0_sel,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic        m0_ack,
  output logic [31:0] m0_dat_sm,

  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_ms,
  input  logic [3:0]  m1_sel,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic        m1_ack,
  output logic [31:0] m1_dat_sm,

  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_ms,
  output logic [3:0]  s_sel,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  input  logic        s_ack,
  input  logic [31:0] s_dat_sm,

  output logic [1:0]  grant
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t           state_q;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             last_owner_q;

  logic hold_full;
  assign hold_full = (hold_cnt_q == HOLD_LAST);

  // Arbitration FSM; grant is registered alongside the state it decodes.
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || last_owner_q)) begin
            state_q      <= GNT0;
            grant_q      <= 2'b01;
            last_owner_q <= 1'b0;
            hold_cnt_q   <= '0;
          end else if (m1_cyc) begin
            state_q      <= GNT1;
            grant_q      <= 2'b10;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
          end
        end
        GNT0: begin
          if ((!m0_cyc && m1_cyc) || (m0_cyc && s_ack && hold_full && m1_cyc)) begin
            state_q      <= GNT1;
            grant_q      <= 2'b10;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
          end else if (!m0_cyc) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            hold_cnt_q <= '0;
          end else if (s_ack && !hold_full) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        GNT1: begin
          if ((!m1_cyc && m0_cyc) || (m1_cyc && s_ack && hold_full && m0_cyc)) begin
            state_q      <= GNT0;
            grant_q      <= 2'b01;
            last_owner_q <= 1'b0;
            hold_cnt_q   <= '0;
          end else if (!m1_cyc) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            hold_cnt_q <= '0;
          end else if (s_ack && !hold_full) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_q    <= 2'b00;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  // Zero-latency request/ack steering; idle parks the slave on master 0's fields.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = m0_we;
    s_adr    = m0_adr;
    s_dat_ms = m0_dat_ms;
    s_sel    = m0_sel;
    s_cti    = m0_cti;
    s_bte    = m0_bte;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_q)
      GNT0: begin
        s_cyc  = m0_cyc;
        s_stb  = m0_stb;
        m0_ack = s_ack;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign grant     = grant_q;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: vector table, directed corner sequences,
// and randomized traffic against an owner/tenure reference model.
module tb_wshb_arbiter;

  localparam int unsigned HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms;
  logic [3:0]  m0_sel;
  logic [2:0]  m0_cti;
  logic [1:0]  m0_bte;
  logic        m0_ack;
  logic [31:0] m0_dat_sm;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms;
  logic [3:0]  m1_sel;
  logic [2:0]  m1_cti;
  logic [1:0]  m1_bte;
  logic        m1_ack;
  logic [31:0] m1_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_ack;
  logic [31:0] s_dat_sm;
  logic [1:0]  grant;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: current owner (-1 idle), acks in this tenure, last owner.
  int m_owner  = -1;
  int m_tenure = 0;
  int m_last   = 1;

  always #5 clk = ~clk;

  wshb_arbiter #(.HOLD_MAX(HOLD)) dut (
    .wshb_clk(clk), .wshb_rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  typedef struct {
    logic       rst_n;
    logic       c0, s0, c1, s1, ack;
    logic [1:0] exp_grant;
    logic       exp_scyc, exp_a0, exp_a1;
    logic       exp_src;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic randomize_fields();
    m0_we = 1'($urandom); m0_adr = $urandom; m0_dat_ms = $urandom;
    m0_sel = 4'($urandom); m0_cti = 3'($urandom); m0_bte = 2'($urandom);
    m1_we = 1'($urandom); m1_adr = $urandom; m1_dat_ms = $urandom;
    m1_sel = 4'($urandom); m1_cti = 3'($urandom); m1_bte = 2'($urandom);
    s_dat_sm = $urandom;
  endtask

  task automatic drive(input logic r, input logic c0, input logic s0,
                       input logic c1, input logic s1, input logic ack);
    rst_n = r; m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack;
    randomize_fields();
  endtask

  // Advance one rising edge and apply the arbitration rules to the model.
  task automatic tick();
    int nxt, own_req, oth_req;
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1; m_tenure = 0; m_last = 1;
    end else begin
      nxt = m_owner;
      if (m_owner < 0) begin
        if (m0_cyc && m1_cyc) nxt = 1 - m_last;
        else if (m0_cyc)      nxt = 0;
        else if (m1_cyc)      nxt = 1;
      end else begin
        own_req = (m_owner == 0) ? int'(m0_cyc) : int'(m1_cyc);
        oth_req = (m_owner == 0) ? int'(m1_cyc) : int'(m0_cyc);
        if (own_req == 0) nxt = (oth_req != 0) ? 1 - m_owner : -1;
        else if (s_ack && (m_tenure + 1 >= int'(HOLD)) && oth_req != 0) nxt = 1 - m_owner;
      end
      if (nxt != m_owner) begin
        m_tenure = 0;
        if (nxt >= 0) m_last = nxt;
      end else if (m_owner >= 0 && s_ack) begin
        m_tenure++;
      end
      m_owner = nxt;
    end
  endtask

  task automatic check_model();
    logic [1:0] eg;
    logic ecyc, estb, a0, a1, src1;
    eg   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    src1 = (m_owner == 1);
    ecyc = (m_owner == 0) ? m0_cyc : (m_owner == 1) ? m1_cyc : 1'b0;
    estb = (m_owner == 0) ? m0_stb : (m_owner == 1) ? m1_stb : 1'b0;
    a0   = s_ack && (m_owner == 0);
    a1   = s_ack && (m_owner == 1);
    chk("rnd_grant", 32'(grant), 32'(eg));
    chk("rnd_s_cyc", 32'(s_cyc), 32'(ecyc));
    chk("rnd_s_stb", 32'(s_stb), 32'(estb));
    chk("rnd_s_we", 32'(s_we), 32'(src1 ? m1_we : m0_we));
    chk("rnd_s_adr", s_adr, src1 ? m1_adr : m0_adr);
    chk("rnd_s_dat_ms", s_dat_ms, src1 ? m1_dat_ms : m0_dat_ms);
    chk("rnd_s_sel", 32'(s_sel), 32'(src1 ? m1_sel : m0_sel));
    chk("rnd_s_cti", 32'(s_cti), 32'(src1 ? m1_cti : m0_cti));
    chk("rnd_s_bte", 32'(s_bte), 32'(src1 ? m1_bte : m0_bte));
    chk("rnd_m0_ack", 32'(m0_ack), 32'(a0));
    chk("rnd_m1_ack", 32'(m1_ack), 32'(a1));
    chk("rnd_m0_dat_sm", m0_dat_sm, s_dat_sm);
    chk("rnd_m1_dat_sm", m1_dat_sm, s_dat_sm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  vec_t tbl [15];

  initial begin
    // rst  c0   s0   c1   s1   ack  | grant  scyc a0   a1   src
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
      #1;
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
      chk($sformatf("tbl%0d_s_cyc", i), 32'(s_cyc), 32'(tbl[i].exp_scyc));
      chk($sformatf("tbl%0d_m0_ack", i), 32'(m0_ack), 32'(tbl[i].exp_a0));
      chk($sformatf("tbl%0d_m1_ack", i), 32'(m1_ack), 32'(tbl[i].exp_a1));
      chk($sformatf("tbl%0d_s_adr", i), s_adr, tbl[i].exp_src ? m1_adr : m0_adr);
      chk($sformatf("tbl%0d_dat_sm", i), m0_dat_sm ^ m1_dat_sm ^ s_dat_sm, s_dat_sm);
      tick();
    end

    // Ack withheld under contention: owner keeps the bus, then 4 acks and handover.
    do_reset();
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
      chk("stall_grant", 32'(grant), 32'(2'b01));
      chk("stall_acks", 32'({m0_ack, m1_ack}), 32'(2'b00));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #1;
      chk("hold0_grant", 32'(grant), 32'(2'b01));
      chk("hold0_m0_ack", 32'(m0_ack), 32'(1'b1));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #1;
      chk("hold1_grant", 32'(grant), 32'(2'b10));
      chk("hold1_m0_ack", 32'(m0_ack), 32'(1'b0));
      chk("hold1_m1_ack", 32'(m1_ack), 32'(1'b1));
      tick();
    end
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    chk("rr_back_grant", 32'(grant), 32'(2'b01));
    tick();

    // Lone requester: bus stays granted while the counter saturates.
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); #1;
    chk("lone_idle_grant", 32'(grant), 32'(2'b00));
    chk("lone_idle_s_cyc", 32'(s_cyc), 32'(1'b0));
    tick();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); #1;
      chk("lone_grant", 32'(grant), 32'(2'b10));
      chk("lone_m1_ack", 32'(m1_ack), 32'(1'b1));
      tick();
    end
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); #1;
    chk("sat_preempt_before", 32'(grant), 32'(2'b10));
    tick();
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    chk("sat_preempt_after", 32'(grant), 32'(2'b01));
    tick();

    // Owner releases with the other waiting: direct handover and live pass-through.
    do_reset();
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    chk("hand_own_grant", 32'(grant), 32'(2'b01));
    tick();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #1;
    chk("hand_drop_grant", 32'(grant), 32'(2'b01));
    chk("hand_drop_s_cyc", 32'(s_cyc), 32'(1'b0));
    tick();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk("hand_new_grant", 32'(grant), 32'(2'b10));
    chk("hand_new_s_cyc", 32'(s_cyc), 32'(1'b1));
    chk("hand_stb_lo", 32'(s_stb), 32'(1'b0));
    m1_stb = 1'b1; m1_adr = $urandom; #1;
    chk("hand_stb_hi", 32'(s_stb), 32'(1'b1));
    chk("hand_adr", s_adr, m1_adr);
    tick();

    // Randomized traffic with occasional reset pulses against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      #1;
      check_model();
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 64: maximum acknowledged transfers one master may hold the bus while the other master is requesting.
REQ-002 wshb_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 wshb_rst_n  in  1  reset, synchronous and active-low.
REQ-004 m0_cyc, m0_stb, m0_we  in  1 each  master 0 (video reader) cycle, strobe and write enable.
REQ-005 m0_adr  in  32, m0_dat_ms  in  32, m0_sel  in  4, m0_cti  in  3, m0_bte  in  2  master 0 request fields.
REQ-006 m0_ack  out  1, m0_dat_sm  out  32  master 0 acknowledge and read data.
REQ-007 m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte: inputs with the same widths as the m0_* fields; m1_ack, m1_dat_sm: outputs; master 1 is the frame writer.
REQ-008 s_cyc, s_stb, s_we  out  1, s_adr  out  32, s_dat_ms  out  32, s_sel  out  4, s_cti  out  3, s_bte  out  2  shared SDRAM slave port.
REQ-009 s_ack  in  1, s_dat_sm  in  32  slave acknowledge and read data.
REQ-010 grant  out  2  one-hot owner: 2'b01 = master 0, 2'b10 = master 1, 2'b00 = idle.

Function
REQ-011 FSM states: IDLE, GNT0, GNT1; grant is a registered decode of the state.
REQ-012 Request: master k requests when mk_cyc=1; stb is ignored for arbitration.
REQ-013 IDLE: if exactly one master requests, enter its GNTk on the next edge.
REQ-014 IDLE, both requesting: grant the master other than last_owner; last_owner is a 1-bit register updated on every entry into GNTk.
REQ-015 GNTk, mk_cyc=0: if the other master requests, enter the other GNT state on the next edge, otherwise enter IDLE.
REQ-016 GNTk, mk_cyc=1: stay in GNTk unless the preemption condition of REQ-017 holds.
REQ-017 Preemption: hold_cnt counts s_ack cycles while in GNTk; when s_ack=1, hold_cnt=HOLD_MAX-1 and the other master requests, switch to the other GNT state on the next edge.
REQ-018 hold_cnt width is $clog2(HOLD_MAX)+1; it clears to 0 on every state change and saturates at HOLD_MAX-1 when the other master is not requesting.
REQ-019 Slave side in GNTk: s_* request fields are the combinational pass-through of mk_*; s_cyc=mk_cyc and s_stb=mk_stb.
REQ-020 Slave side in IDLE: s_cyc=0 and s_stb=0; the other s_* fields carry master 0's values.
REQ-021 Acknowledge: mk_ack = s_ack AND (state==GNTk); the non-owner sees ack=0 and therefore stalls with its stb held.
REQ-022 Read data: m0_dat_sm and m1_dat_sm both equal s_dat_sm at all times.
REQ-023 Arbitration adds 1 cycle of latency: a request arriving in IDLE reaches s_cyc on the cycle after it is sampled; pass-through within a grant adds 0 cycles.
REQ-024 No transfer may be lost at a handover: a switch occurs only on an ack edge (REQ-017) or when the owner's cyc=0 (REQ-015).
REQ-025 The same master regains the bus after preemption only through the normal round-robin order.

Reset
REQ-026 While wshb_rst_n=0 at a rising edge: state=IDLE, grant=2'b00, hold_cnt=0, last_owner=1, so master 0 wins the first tie.
REQ-027 Reset asserted mid-grant: at the next edge s_cyc=s_stb=0 and m0_ack=m1_ack=0, and the aborted transfer is not completed.

Verification
REQ-028 Reset release, m0_cyc=m1_cyc=1 simultaneously -> grant=01 one cycle later; s_adr equals m0_adr.
REQ-029 HOLD_MAX=4, both masters requesting, slave acks every cycle -> master 0 gets exactly 4 acks, then grant=10 on the next edge; m0_ack=0 throughout master 1's grant.
REQ-030 Only m1_cyc=1 continuously, slave acks every cycle -> grant stays 10 indefinitely, hold_cnt saturates at 3 and no switch occurs.
REQ-031 GNT0, m0_cyc drops while m1_cyc=1 -> grant=10 on the next edge with no IDLE cycle; the new grant then has 0-cycle pass-through.
REQ-032 Owner's stb=1 with s_ack withheld for 10 cycles while the other master requests -> no switch; grant is unchanged until an ack occurs.
REQ-033 wshb_rst_n=0 for one cycle during a master 1 burst -> grant=00, s_cyc=0; after release with both requesting, grant=01.
